// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// alignment mask and width helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Any set bit under this mask on a byte address means a misaligned word access.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  // Bit width needed to index `value` items, never less than one bit.
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM. The storage itself is not reset;
// only the read register is, so rdata starts at zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we,
  input  logic             re,
  input  logic             rzero,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port: one word per cycle when we is asserted.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  // Read register: loads the addressed word, or zero for a rejected load,
  // and otherwise holds the last completed load value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= rzero ? 32'd0 : mem[index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. A request seen in
// IDLE is latched, held for LATENCY cycles in BUSY while the pipeline is
// stalled, then completed with a one-cycle ack in DONE.
//
// Handshake: req_i is a level request; stall_o is high from the first cycle
// req_i is seen in IDLE through the last BUSY cycle. ack_o pulses for exactly
// one cycle (DONE) with stall_o low, and the pipeline consumes the result at
// the end of that cycle. A request still high during DONE belongs to the
// completed access; a new access is only accepted from IDLE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = clog2_min1(DEPTH_WORDS);
  localparam int CNT_W = clog2_min1(LATENCY);

  state_t      state;
  state_t      next_state;
  logic [CNT_W-1:0] cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        fire;
  logic        access_err;
  logic        mem_we;
  logic        mem_re;

  // A request is only taken in IDLE; the access happens on the last BUSY cycle.
  assign accept     = (state == ST_IDLE) && req_i;
  assign fire       = (state == ST_BUSY) && (cnt == '0);
  assign access_err = ((addr_q[1:0] & MISALIGN_MASK) != 2'b00) ||
                      (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign mem_we     = fire && we_q && !access_err;
  assign mem_re     = fire && !we_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stall decode; the unused encoding falls back to IDLE.
  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_o = req_i;
        if (req_i) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (cnt == '0) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Latency counter: loaded on accept, counts down to zero in BUSY.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(LATENCY - 1);
    end else if ((state == ST_BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request latches: inputs are captured once, so churn during BUSY is ignored.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Completion flags are registered so they are high exactly in DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= fire;
      err_o <= fire && access_err;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we      (mem_we),
    .re      (mem_re),
    .rzero   (access_err),
    .index   (addr_q[IDX_W+1:2]),
    .wdata   (wdata_q),
    .rdata   (rdata_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: drives directed and random load/store traffic,
// predicts each response from a word-array model of the memory, and checks
// acks through a scoreboard queue plus cycle-exact stall/ack timing.
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LAT     = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .stall_o (stall),
    .ack_o   (ack),
    .rdata_o (rdata),
    .err_o   (err)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd = 32'd0;
  logic [32:0] exp_q [$];   // {err, rdata}
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one access to the model and return the expected {err, rdata}.
  function automatic logic [32:0] model_access(input bit is_st, input logic [31:0] a,
                                               input logic [31:0] d);
    bit bad;
    int unsigned widx;
    widx = a >> 2;
    bad  = (a % 4 != 0) || (widx >= DEPTH);
    if (is_st) begin
      if (!bad) model_mem[widx] = d;
    end else begin
      model_rd = bad ? 32'd0 : model_mem[widx];
    end
    return {bad, model_rd};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && ack) begin
      logic [32:0] e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_rdata", rdata, e[31:0]);
        check("ack_err", {31'd0, err}, {31'd0, e[32]});
      end
    end
  end

  // ---------------- driver ----------------
  // One access starting in the cycle after the next rising edge. Checks
  // stall high for LAT+1 cycles then ack with stall low. churn scrambles
  // addr/wdata during BUSY; hold keeps req high through DONE.
  task automatic do_access(input bit is_st, input logic [31:0] a, input logic [31:0] d,
                           input bit churn, input bit hold);
    @(posedge clk); #1;
    req = 1'b1; we = is_st; addr = a; wdata = d;
    exp_q.push_back(model_access(is_st, a, d));
    @(negedge clk);
    check("stall_first", {31'd0, stall}, 32'd1);
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
      if (churn) begin
        addr = $urandom_range(0, DEPTH - 1) << 2;
        wdata = $urandom;
        we = $urandom_range(0, 1);
      end
      @(negedge clk);
      check("stall_busy", {31'd0, stall}, 32'd1);
      check("ack_busy", {31'd0, ack}, 32'd0);
    end
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    @(negedge clk);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("ack_done", {31'd0, ack}, 32'd1);
  endtask

  // One idle cycle with req low: nothing must be pending.
  task automatic idle_cycle();
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_ack", {31'd0, ack}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    if (sel == 1) return (32'(DEPTH) << 2) + (32'($urandom_range(0, 1000)) << 2);
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    #2;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    req = 1'b1; #1;
    check("rst_stall_follows_req", {31'd0, stall}, 32'd1);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Give every word a known value (word 16 / byte 0x40 kept away from 0xDEADBEEF).
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = (i == 16) ? 32'hCAFE_0016 : $urandom;
      do_access(1'b1, 32'(i) << 2, v, 1'b0, 1'b0);
    end

    // Store then load.
    do_access(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
    do_access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    check("load_0x10_value", model_rd, 32'h1234_5678);

    // Misaligned / out-of-range loads and a misaligned store.
    do_access(1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    do_access(1'b0, 32'(DEPTH * 4), 32'h0, 1'b0, 1'b0);
    do_access(1'b1, 32'h13, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    do_access(1'b0, 32'h14, 32'h0, 1'b0, 1'b0);
    do_access(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);

    // Held request: one ack, then a gap, then held request restarting from IDLE.
    do_access(1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
    idle_cycle();
    do_access(1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
    do_access(1'b0, 32'h24, 32'h0, 1'b0, 1'b0);
    idle_cycle();

    // Input churn during BUSY, then read back the latched address.
    do_access(1'b1, 32'h30, 32'hA5A5_0030, 1'b1, 1'b0);
    do_access(1'b0, 32'h30, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of a store: no write, no ack, outputs cleared.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    #1;
    check("abort_ack", {31'd0, ack}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    model_rd = 32'd0;
    repeat (LAT + 2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();
    do_access(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    check("abort_no_write", {31'd0, model_rd == 32'hDEAD_BEEF}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 120; n++) begin
      do_access($urandom_range(0, 1), rand_addr(), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
